// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    // ALUControl encodings (3 significant bits, zero-extended to ALUCTRL_W)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // Instruction class (IR[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // Data-processing command field (IR[24:21])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition field (IR[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_mc_condlogic.sv
// Condition logic: architectural NZCV flags, condition evaluation at decode
// and the latched pass/fail result used by the remaining instruction states.
module arm_mc_condlogic
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic [3:0] cond_i,
    input  logic       latch_i,
    input  logic [3:0] alu_flags_i,
    input  logic       nz_upd_i,
    input  logic       cv_upd_i,
    output logic       cond_o,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;

    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, res;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            COND_NV: res = 1'b1;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Latch the condition at decode; flags only change for instructions that passed it
    always_comb begin
        cond_d  = cond_q;
        flags_d = flags_q;
        if (latch_i) begin
            cond_d = cond_check(cond_i, flags_q);
        end
        if (nz_upd_i && cond_q) begin
            flags_d[3:2] = alu_flags_i[3:2];
        end
        if (cv_upd_i && cond_q) begin
            flags_d[1:0] = alu_flags_i[1:0];
        end
    end

    // Flag and condition registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cond_q  <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            cond_q  <= cond_d;
            flags_q <= flags_d;
        end
    end

    assign cond_o  = cond_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: instruction decoders plus the sequencing FSM
// that drives the shared-memory multicycle datapath.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int EXT_OPS       = 1,
    parameter int ALUCTRL_W     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [19:0]          Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_pc;
    logic       ready;
    logic       cond_q;
    logic [3:0] flags_unused;
    logic       unused_rn;

    logic       dp_legal, dp_cv, dp_nowb;
    logic [2:0] dp_alu;

    logic       pcw, irw, rw, mw, ill;
    logic       nz_upd, cv_upd, cond_latch;
    logic [2:0] alu_sel;

    // Instr carries IR[31:12]: cond, op, funct, Rn, Rd
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign cmd       = funct[4:1];
    assign rd_pc     = (Instr[3:0] == 4'hF);
    assign unused_rn = ^Instr[7:4];

    assign ready = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    assign ImmSrc = op;
    assign RegSrc = {op == OP_BR, op == OP_MEM};

    arm_mc_condlogic u_cond (
        .clk         (clk),
        .rst_n_i     (reset),
        .cond_i      (Instr[19:16]),
        .latch_i     (cond_latch),
        .alu_flags_i (ALUFlags),
        .nz_upd_i    (nz_upd),
        .cv_upd_i    (cv_upd),
        .cond_o      (cond_q),
        .flags_o     (flags_unused)
    );

    // Data-processing command decode: ALU op, CV update, result suppression, legality
    always_comb begin
        dp_legal = 1'b1;
        dp_alu   = ALU_ADD;
        dp_cv    = 1'b0;
        dp_nowb  = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
            CMD_AND: dp_alu = ALU_AND;
            CMD_ORR: dp_alu = ALU_ORR;
            CMD_EOR: begin
                dp_alu   = ALU_EOR;
                dp_legal = (EXT_OPS != 0);
            end
            CMD_CMP: begin
                dp_alu   = ALU_SUB;
                dp_cv    = 1'b1;
                dp_nowb  = 1'b1;
                dp_legal = (EXT_OPS != 0) && funct[0];
            end
            CMD_TST: begin
                dp_alu   = ALU_AND;
                dp_nowb  = 1'b1;
                dp_legal = (EXT_OPS != 0) && funct[0];
            end
            default: dp_legal = 1'b0;
        endcase
    end

    // Next state and per-state controls; defaults are the FETCH select values
    always_comb begin
        state_d    = state_q;
        pcw        = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        mw         = 1'b0;
        ill        = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b10;
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        alu_sel    = ALU_ADD;
        nz_upd     = 1'b0;
        cv_upd     = 1'b0;
        cond_latch = 1'b0;
        case (state_q)
            FETCH: begin
                irw = ready;
                pcw = ready;
                if (ready) state_d = DECODE;
            end
            DECODE: begin
                cond_latch = 1'b1;
                case (op)
                    OP_MEM: state_d = MEMADR;
                    OP_BR:  state_d = BRANCH;
                    OP_DP: begin
                        if (!dp_legal) begin
                            ill     = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = funct[5] ? EXECI : EXECR;
                        end
                    end
                    OP_UND: begin
                        ill     = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b00;
                ALUSrcB = 2'b01;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                rw        = cond_q;
                pcw       = cond_q & rd_pc;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mw     = cond_q;
                // A failed store never starts an access, so there is nothing to wait for
                if (ready || !cond_q) state_d = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcA = 2'b00;
                ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_sel = dp_alu;
                nz_upd  = funct[0];
                cv_upd  = funct[0] & dp_cv;
                state_d = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                rw        = cond_q & ~dp_nowb;
                pcw       = cond_q & ~dp_nowb & rd_pc;
                state_d   = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b00;
                ALUSrcB = 2'b01;
                pcw     = cond_q;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State register; reset forces FETCH at once, even mid-access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Enables are masked while reset is held so the FETCH state cannot strobe
    assign PCWrite    = reset & pcw;
    assign IRWrite    = reset & irw;
    assign RegWrite   = reset & rw;
    assign MemWrite   = reset & mw;
    assign Illegal    = reset & ill;
    assign ALUControl = ALUCTRL_W'(alu_sel);

endmodule
